alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Execute stage that consumes the 3-bit ALU opcode (ADD, LSH, RSH, XOR, AND, SUB, CLR) plus two operands and produces a registered result with carry/zero flags.
- Single-cycle ops complete in one cycle after accept.
- Shifts run serially, one bit per cycle.
- valid/ready handshake on both sides; sits between decode/register-read and writeback.

Parameters:
WIDTH, 8, operand/result width in bits
SHAMT_W, 3, number of low bits of b used as shift amount

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents op/a/b
in_ready  output  1  stage can accept this cycle
op  input  3  opcode, definition::op_name encoding
a  input  WIDTH  operand A / shift source
b  input  WIDTH  operand B; b[SHAMT_W-1:0] = shift amount for LSH/RSH
out_valid  output  1  result/flags valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  registered result
carry  output  1  carry/borrow/last shifted-out bit
zero  output  1  result == 0
illegal  output  1  op was 3'b111 (unencoded)

Behaviour:
- Reset (synchronous, active-high) has priority over everything:
  - state=IDLE; out_valid=0; result=0; carry=0; zero=0; illegal=0.
  - Any in-flight shift is abandoned and its result is discarded.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept = in_valid && in_ready.
- On accept, the stage latches op, a, b and the shift count.
- Non-shift op, or LSH/RSH with count 0: next state DONE. result/flags computed and registered at accept, so out_valid rises the cycle after accept (latency 1).
- LSH/RSH with count n>0:
  - Next state SHIFT. An accumulator is loaded with a and the counter with n.
  - Each SHIFT cycle shifts by 1 and decrements the counter.
  - On the cycle the counter reaches 0, the result is registered and the state moves to DONE.
  - out_valid rises n+1 cycles after accept. in_ready=0 throughout SHIFT.
- DONE:
  - out_valid=1. result/carry/zero/illegal held stable while out_ready=0.
  - On out_ready=1 without a new accept: IDLE, out_valid=0 next cycle.
  - On out_ready=1 with a simultaneous accept: back-to-back, no bubble, next state per new op.
- Arithmetic, width WIDTH, all modulo 2^WIDTH:
  - ADD: {carry,result} = a+b, computed at WIDTH+1 bits.
  - SUB: result = a-b; carry = borrow = (a<b).
  - XOR, AND: bitwise; carry=0.
  - CLR: result=0; carry=0.
  - LSH (logical): per step carry<=acc[WIDTH-1], acc<=acc<<1.
  - RSH (logical): per step carry<=acc[0], acc<=acc>>1. Final carry = last bit shifted out.
  - Shift with count 0: result=a, carry=0.
  - op 3'b111: result=0, carry=0, illegal=1, latency 1. All other ops set illegal=0.
  - zero = (registered result == 0), for every op.
- Boundary cases:
  - in_valid while in SHIFT or DONE with out_ready=0: ignored, not accepted; upstream holds its inputs.
  - op/a/b changes after accept have no effect on the op in flight.
  - Maximum shift count 2^SHAMT_W-1 = 7 gives latency 8.

Decomposition:
- Package definition: keep op_name and the k* opcode constants. Add typedef enum alu_state_t {IDLE, SHIFT, DONE}.
- Optional sub-module alu_comb_core: purely combinational ADD/SUB/XOR/AND/CLR/illegal result+carry, instantiated once.
- Shift accumulator, counter and FSM stay in alu_exec_stage.

Test Plan:
- ADD a=0xF0 b=0x20, out_ready=1 -> out_valid the cycle after accept; result=0x10, carry=1, zero=0.
- SUB 0x05-0x07 -> result=0xFE, carry=1. Then SUB 0x07-0x07 back-to-back -> result=0x00, carry=0, zero=1, no bubble.
- LSH a=0x81 b=3 -> in_ready=0 for 3 SHIFT cycles; out_valid at accept+4; result=0x08, carry=0. RSH a=0x81 b=1 -> accept+2, result=0x40, carry=1. LSH b=0 -> latency 1, result=0x81, carry=0.
- XOR a=0xAA b=0xFF with out_ready=0 for 5 cycles -> result=0x55 held stable, in_ready=0. Then out_ready=1 with in_valid and AND 0x0F&0x3C -> accepted same cycle; next result=0x0C.
- LSH b=7 accepted, reset=1 on the 3rd SHIFT cycle -> next cycle out_valid=0, result=0, in_ready=1. A new ADD 1+1 then yields 0x02.
- op=3'b111 a=0x12 b=0x34 -> result=0x00, illegal=1, zero=1. Following CLR -> illegal=0.

Source files
------------

// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode and state definitions for the ALU execute stage.
package alu_exec_stage_pkg;

    typedef enum logic [2:0] {
        kAdd     = 3'd0,
        kLsh     = 3'd1,
        kRsh     = 3'd2,
        kXor     = 3'd3,
        kAnd     = 3'd4,
        kSub     = 3'd5,
        kClr     = 3'd6,
        kIllegal = 3'd7
    } op_name;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } alu_state_t;

    function automatic logic isShiftOp(input op_name opCode);
        return (opCode == kLsh) || (opCode == kRsh);
    endfunction

endpackage

// File: rtl/alu_exec_stage_comb_core.sv
// Single-cycle ALU datapath; shift opcodes pass A through (the zero-count shift result).
module alu_comb_core
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_name             opCode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               illegal
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Top bit of the extended difference is the borrow, i.e. a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result  = a;
        carry   = 1'b0;
        illegal = 1'b0;
        case (opCode)
            kAdd: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            kSub: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            kXor:     result = a ^ b;
            kAnd:     result = a & b;
            kClr:     result = '0;
            kIllegal: begin
                result  = '0;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle ops via alu_comb_core, serial one-bit-per-cycle shifts.
//   state | meaning
//   IDLE  | empty, ready for a new op
//   SHIFT | serial shift in progress, input stalled
//   DONE  | result valid, waiting for downstream
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               illegal
);

    localparam logic [SHAMT_W-1:0] kCntOne = SHAMT_W'(1);

    alu_state_t           state;
    alu_state_t           nextState;
    logic                 accept;
    op_name               opIn;
    logic [SHAMT_W-1:0]   shamt;
    logic                 startShift;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     accNext;
    logic                 shiftBit;
    logic [SHAMT_W-1:0]   shiftCnt;
    logic                 shiftLeft;
    logic                 lastStep;
    logic [WIDTH-1:0]     coreResult;
    logic                 coreCarry;
    logic                 coreIllegal;

    assign opIn       = op_name'(op);
    assign shamt      = b[SHAMT_W-1:0];
    assign startShift = isShiftOp(opIn) && (shamt != '0);
    assign lastStep   = (shiftCnt == kCntOne);
    assign out_valid  = (state == DONE);

    alu_comb_core #(.WIDTH(WIDTH)) uCore (
        .opCode  (opIn),
        .a       (a),
        .b       (b),
        .result  (coreResult),
        .carry   (coreCarry),
        .illegal (coreIllegal)
    );

    always_comb begin
        accNext  = shiftLeft ? (acc << 1) : (acc >> 1);
        shiftBit = shiftLeft ? acc[WIDTH-1] : acc[0];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE:  in_ready = 1'b1;
            SHIFT: if (lastStep) nextState = DONE;
            DONE: begin
                in_ready = out_ready;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) nextState = startShift ? SHIFT : DONE;
    end

    // Result registers only change on a single-cycle accept or the final shift step.
    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            acc       <= '0;
            shiftCnt  <= '0;
            shiftLeft <= 1'b0;
        end else if (accept) begin
            if (startShift) begin
                acc       <= a;
                shiftCnt  <= shamt;
                shiftLeft <= (opIn == kLsh);
            end else begin
                result  <= coreResult;
                carry   <= coreCarry;
                zero    <= (coreResult == '0);
                illegal <= coreIllegal;
            end
        end else if (state == SHIFT) begin
            acc      <= accNext;
            shiftCnt <= shiftCnt - kCntOne;
            if (lastStep) begin
                result  <= accNext;
                carry   <= shiftBit;
                zero    <= (accNext == '0);
                illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed cases plus randomized ops against an arithmetic model.
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       illegal;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0] expR;
    logic       expC;
    logic       expIl;
    int         expLat;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] r, output logic c, output logic il,
                                  output int lat);
        int n;
        int t;
        n   = int'(y) % 8;
        t   = 0;
        r   = 8'h00;
        c   = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (o)
            3'd0: begin t = int'(x) + int'(y); r = t[7:0]; c = t[8]; end
            3'd1: begin t = int'(x) << n; r = t[7:0]; c = t[8]; lat = n + 1; end
            3'd2: begin
                r = x >> n;
                if (n > 0) begin t = int'(x) >> (n - 1); c = t[0]; end
                lat = n + 1;
            end
            3'd3: r = x ^ y;
            3'd4: r = x & y;
            3'd5: begin t = int'(x) - int'(y); r = t[7:0]; c = (x < y); end
            3'd6: r = 8'h00;
            default: il = 1'b1;
        endcase
    endfunction

    task automatic checkOutputs(input string tag);
        checkVal({tag, "_result"}, result, expR);
        checkVal({tag, "_carry"}, carry, expC);
        checkVal({tag, "_zero"}, zero, (expR == 8'h00));
        checkVal({tag, "_illegal"}, illegal, expIl);
    endtask

    // Called just after a negedge; leaves the stage in DONE with out_ready low.
    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int lat;
        model(o, x, y, expR, expC, expIl, expLat);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        checkVal("in_ready_accept", in_ready, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'($urandom);
        a         = 8'($urandom);
        b         = 8'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat <= 12) begin
            checkVal("in_ready_busy", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        checkVal("latency", lat, expLat);
        checkOutputs("op");
    endtask

    task automatic holdDone(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            op       = 3'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            #1;
            checkVal("hold_in_ready", in_ready, 0);
            @(negedge clk);
            checkVal("hold_out_valid", out_valid, 1);
            checkOutputs("hold");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        checkVal("drain_out_valid", out_valid, 0);
        checkVal("drain_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = 8'h00;
        b         = 8'h00;
        repeat (3) @(negedge clk);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_result", result, 8'h00);
        checkVal("rst_carry", carry, 0);
        checkVal("rst_zero", zero, 0);
        checkVal("rst_illegal", illegal, 0);
        checkVal("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        issue(kAdd, 8'hF0, 8'h20); drain();
        issue(kSub, 8'h05, 8'h07);
        out_ready = 1'b1;
        issue(kSub, 8'h07, 8'h07); drain();
        issue(kLsh, 8'h81, 8'h03); drain();
        issue(kRsh, 8'h81, 8'h01); drain();
        issue(kLsh, 8'h81, 8'h00); drain();
        issue(kXor, 8'hAA, 8'hFF); holdDone(5);
        out_ready = 1'b1;
        issue(kAnd, 8'h0F, 8'h3C); drain();
        issue(kRsh, 8'hC3, 8'h07); drain();

        // Reset during the third shift cycle of a maximum-length shift.
        op = kLsh; a = 8'h81; b = 8'h07; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkVal("midrst_out_valid", out_valid, 0);
        checkVal("midrst_result", result, 8'h00);
        checkVal("midrst_in_ready", in_ready, 1);
        reset = 1'b0;
        @(negedge clk);
        checkVal("midrst_settled", out_valid, 0);
        issue(kAdd, 8'h01, 8'h01); drain();

        issue(3'b111, 8'h12, 8'h34); drain();
        issue(kClr, 8'h12, 8'h34); drain();

        for (int i = 0; i < 200; i++) begin
            logic [2:0] ro;
            logic [7:0] ra;
            logic [7:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 1) == 1) out_ready = 1'b1;
            else drain();
            issue(ro, ra, rb);
            if ($urandom_range(0, 3) == 0) holdDone(int'($urandom_range(1, 3)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
